// File: rtl/platform_manager.sv
// platform_manager: builds, scrolls and respawns 16 platforms and keeps a climb score; define PLAT_MOVING_EN for drifting odd platforms.
module platform_manager #(
  parameter int SCROLL_LINE = 200,
  parameter int SPACING = 30,
  parameter int X_MIN = 32,
  parameter int X_RANGE = 448,
  parameter int START_X = 320,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic Clk,
  input logic Reset,
  input logic frame_clk,
  input logic loadplat,
  input logic [9:0] DoodleY,
  input logic [9:0] Doodle_Y_Motion,
  output logic [8:0] platX0,
  output logic [8:0] platX1,
  output logic [8:0] platX2,
  output logic [8:0] platX3,
  output logic [8:0] platX4,
  output logic [8:0] platX5,
  output logic [8:0] platX6,
  output logic [8:0] platX7,
  output logic [8:0] platX8,
  output logic [8:0] platX9,
  output logic [8:0] platX10,
  output logic [8:0] platX11,
  output logic [8:0] platX12,
  output logic [8:0] platX13,
  output logic [8:0] platX14,
  output logic [8:0] platX15,
  output logic [8:0] platY0,
  output logic [8:0] platY1,
  output logic [8:0] platY2,
  output logic [8:0] platY3,
  output logic [8:0] platY4,
  output logic [8:0] platY5,
  output logic [8:0] platY6,
  output logic [8:0] platY7,
  output logic [8:0] platY8,
  output logic [8:0] platY9,
  output logic [8:0] platY10,
  output logic [8:0] platY11,
  output logic [8:0] platY12,
  output logic [8:0] platY13,
  output logic [8:0] platY14,
  output logic [8:0] platY15,
  output logic [3:0] scroll_amt,
  output logic [15:0] score,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SCROLL, COMMIT} stateT;
  localparam logic [9:0] SPC = 10'(SPACING);
  localparam logic [9:0] SL = 10'(SCROLL_LINE);
  localparam logic [8:0] XMIN = 9'(X_MIN);
  localparam logic [8:0] XRNG = 9'(X_RANGE);
  localparam logic [8:0] SX = 9'(START_X);
  stateT state, nextState;
  logic [2:0] frameSync;
  logic [1:0] loadSync;
  logic frameTick, loadReq, startLoad, scrollGo, respawn;
  logic [3:0] index, shiftReg, shiftCalc;
  logic [15:0] lfsr, lfsrNext;
  logic [8:0] workX [16];
  logic [8:0] workY [16];
  logic [8:0] outX [16];
  logic [8:0] outY [16];
  logic [8:0] off, randX, loadY, curY, newY, newX;
  logic [9:0] negMotion, ny;
  logic [16:0] scoreSum;
  assign frameTick = frameSync[1] & ~frameSync[2];
  assign loadReq = loadSync[0] & ~loadSync[1];
  // A load request landing in COMMIT is dropped; everywhere else it (re)starts LOAD.
  assign startLoad = loadReq && state != COMMIT;
  assign busy = state != IDLE;
  assign lfsrNext = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign off = lfsr[8:0] >= XRNG ? lfsr[8:0] - XRNG : lfsr[8:0];
  assign randX = XMIN + off;
  assign negMotion = ~Doodle_Y_Motion + 10'd1;
  assign shiftCalc = (DoodleY < SL && Doodle_Y_Motion[9]) ? (negMotion > 10'd15 ? 4'd15 : negMotion[3:0]) : 4'd0;
  assign scoreSum = {1'b0, score} + 17'(shiftCalc);
  assign loadY = 9'(10'd471 - 10'(index) * SPC);
  assign curY = workY[index];
  assign ny = {1'b0, curY} + {6'd0, shiftReg};
  assign respawn = ny > 10'd479;
  assign newY = respawn ? 9'(ny - 10'd480) : ny[8:0];
`ifdef PLAT_MOVING_EN
  localparam logic [8:0] XMAX = 9'(X_MIN + X_RANGE - 1);
  logic [15:0] dir;
  logic [8:0] baseX;
  logic turn;
  assign scrollGo = 1'b1;
  assign baseX = respawn ? randX : workX[index];
  assign turn = dir[index] ? baseX == XMAX : baseX == XMIN;
  assign newX = !index[0] ? baseX : (dir[index] ^ turn) ? baseX + 9'd1 : baseX - 9'd1;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) dir <= '1;
    else if (!startLoad && state == LOAD) dir[index] <= 1'b1;
    else if (!startLoad && state == SCROLL && index[0] && turn) dir[index] <= ~dir[index];
`else
  assign scrollGo = shiftCalc != 4'd0;
  assign newX = respawn ? randX : workX[index];
`endif
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    if (startLoad) nextState = LOAD;
    else if (state == IDLE) nextState = frameTick && scrollGo ? SCROLL : IDLE;
    else if (state == COMMIT) nextState = IDLE;
    else if (index == 4'd15) nextState = COMMIT;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      frameSync <= '0;
      loadSync <= '0;
      index <= '0;
      shiftReg <= '0;
      lfsr <= LFSR_SEED;
      scroll_amt <= '0;
      score <= '0;
      for (int i = 0; i < 16; i++) begin
        workX[i] <= '0;
        workY[i] <= '0;
        outX[i] <= '0;
        outY[i] <= '0;
      end
    end else begin
      frameSync <= {frameSync[1:0], frame_clk};
      loadSync <= {loadSync[0], loadplat};
      index <= (!startLoad && (state == LOAD || state == SCROLL)) ? index + 4'd1 : 4'd0;
      if (startLoad) begin
        shiftReg <= '0;
        if (state != IDLE) score <= '0;
      end else if (state == IDLE && frameTick && scrollGo) begin
        shiftReg <= shiftCalc;
        score <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
      end else if (state == IDLE && frameTick) scroll_amt <= '0;
      if (!startLoad && state == LOAD) begin
        workX[index] <= index == 4'd0 ? SX : randX;
        workY[index] <= loadY;
        lfsr <= lfsrNext;
      end
      if (!startLoad && state == SCROLL) begin
        workX[index] <= newX;
        workY[index] <= newY;
        if (respawn) lfsr <= lfsrNext;
      end
      if (state == COMMIT) begin
        outX <= workX;
        outY <= workY;
        scroll_amt <= shiftReg;
      end
    end
  assign platX0 = outX[0];
  assign platX1 = outX[1];
  assign platX2 = outX[2];
  assign platX3 = outX[3];
  assign platX4 = outX[4];
  assign platX5 = outX[5];
  assign platX6 = outX[6];
  assign platX7 = outX[7];
  assign platX8 = outX[8];
  assign platX9 = outX[9];
  assign platX10 = outX[10];
  assign platX11 = outX[11];
  assign platX12 = outX[12];
  assign platX13 = outX[13];
  assign platX14 = outX[14];
  assign platX15 = outX[15];
  assign platY0 = outY[0];
  assign platY1 = outY[1];
  assign platY2 = outY[2];
  assign platY3 = outY[3];
  assign platY4 = outY[4];
  assign platY5 = outY[5];
  assign platY6 = outY[6];
  assign platY7 = outY[7];
  assign platY8 = outY[8];
  assign platY9 = outY[9];
  assign platY10 = outY[10];
  assign platY11 = outY[11];
  assign platY12 = outY[12];
  assign platY13 = outY[13];
  assign platY14 = outY[14];
  assign platY15 = outY[15];
endmodule

// File: tb/tb_platform_manager.sv
// tb_platform_manager: randomized frames against a behavioural platform model, plus literal pins.
module tb_platform_manager;
  logic Clk = 0, Reset = 0, frame_clk = 0, loadplat = 0;
  logic [9:0] DoodleY = 0, Doodle_Y_Motion = 0;
  logic [8:0] px [16];
  logic [8:0] py [16];
  logic [3:0] scroll_amt;
  logic [15:0] score;
  logic busy;
  int checks = 0, failures = 0;
  bit chk = 0;
  int mx [16];
  int my [16];
  int mScroll = 0, mScore = 0;
  logic [15:0] mLfsr = 16'hACE1;

  platform_manager dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .loadplat(loadplat),
    .DoodleY(DoodleY), .Doodle_Y_Motion(Doodle_Y_Motion),
    .platX0(px[0]), .platX1(px[1]), .platX2(px[2]), .platX3(px[3]),
    .platX4(px[4]), .platX5(px[5]), .platX6(px[6]), .platX7(px[7]),
    .platX8(px[8]), .platX9(px[9]), .platX10(px[10]), .platX11(px[11]),
    .platX12(px[12]), .platX13(px[13]), .platX14(px[14]), .platX15(px[15]),
    .platY0(py[0]), .platY1(py[1]), .platY2(py[2]), .platY3(py[3]),
    .platY4(py[4]), .platY5(py[5]), .platY6(py[6]), .platY7(py[7]),
    .platY8(py[8]), .platY9(py[9]), .platY10(py[10]), .platY11(py[11]),
    .platY12(py[12]), .platY13(py[13]), .platY14(py[14]), .platY15(py[15]),
    .scroll_amt(scroll_amt), .score(score), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int randX(logic [15:0] l);
    int o = int'(l[8:0]);
    if (o >= 448) o -= 448;
    return 32 + o;
  endfunction

  function automatic logic [15:0] step(logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic modelLoad();
    for (int i = 0; i < 16; i++) begin
      my[i] = 471 - 30 * i;
      mx[i] = i == 0 ? 320 : randX(mLfsr);
      mLfsr = step(mLfsr);
    end
    mScroll = 0;
  endtask

  task automatic modelScroll(int sh);
    for (int i = 0; i < 16; i++) begin
      int ny = my[i] + sh;
      if (ny > 479) begin
        my[i] = ny - 480;
        mx[i] = randX(mLfsr);
        mLfsr = step(mLfsr);
      end else my[i] = ny;
    end
    mScroll = sh;
    mScore = mScore + sh > 65535 ? 65535 : mScore + sh;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    mScroll = 0;
    mScore = 0;
    mLfsr = 16'hACE1;
  endtask

  task automatic waitBusy(logic lvl, int lim, output int ok, output int n);
    ok = 0;
    n = lim;
    for (int i = 0; i < lim; i++) begin
      @(negedge Clk);
      if (busy == lvl) begin
        ok = 1;
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic doLoad(output int cyc);
    int ok, n;
    chk = 0;
    cyc = 0;
    @(negedge Clk);
    loadplat = 1;
    waitBusy(1, 20, ok, n);
    check("load_busy_rise", ok, 1);
    if (ok == 1) begin
      modelLoad();
      waitBusy(0, 40, ok, cyc);
      check("load_busy_fall", ok, 1);
    end
    loadplat = 0;
    chk = 1;
  endtask

  task automatic doFrame(logic [9:0] dy, logic [9:0] mot);
    int ok, n, sh;
    chk = 0;
    @(negedge Clk);
    DoodleY = dy;
    Doodle_Y_Motion = mot;
    frame_clk = 1;
    if (dy < 200 && mot[9]) begin
      waitBusy(1, 20, ok, n);
      check("frame_busy_rise", ok, 1);
      if (ok == 1) begin
        sh = 1024 - int'(mot);
        modelScroll(sh > 15 ? 15 : sh);
        waitBusy(0, 40, ok, n);
        check("frame_busy_fall", ok, 1);
      end
    end else begin
      repeat (8) @(negedge Clk);
      mScroll = 0;
    end
    frame_clk = 0;
    repeat (4) @(negedge Clk);
    chk = 1;
  endtask

  always @(negedge Clk)
    if (chk && !busy) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("platX%0d", i), int'(px[i]), mx[i]);
        check($sformatf("platY%0d", i), int'(py[i]), my[i]);
      end
      check("scroll_amt", int'(scroll_amt), mScroll);
      check("score", int'(score), mScore);
    end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ok, n;
    modelReset();
    chk = 1;
    repeat (5) @(negedge Clk);
    check("reset_busy", int'(busy), 0);
    Reset = 1;
    repeat (50) @(negedge Clk);
    doLoad(cyc);
    check("load_busy_cycles", cyc, 17);
    @(negedge Clk);
    check("lit_Y0", int'(py[0]), 471);
    check("lit_Y15", int'(py[15]), 21);
    check("lit_X0", int'(px[0]), 320);
    for (int i = 1; i < 16; i++)
      check($sformatf("X%0d_in_range", i), int'(px[i] >= 32 && px[i] <= 479), 1);
    doFrame(10'd150, 10'h3FD);
    @(negedge Clk);
    check("lit_score3", int'(score), 3);
    check("lit_scroll3", int'(scroll_amt), 3);
    check("lit_Y0_474", int'(py[0]), 474);
    doFrame(10'd250, 10'h3FD);
    @(negedge Clk);
    check("lit_scroll0", int'(scroll_amt), 0);
    check("lit_Y0_hold", int'(py[0]), 474);
    doFrame(10'd150, 10'h3FD);
    doFrame(10'd150, 10'h3FB);
    @(negedge Clk);
    check("lit_respawn_Y0", int'(py[0]), 2);
    check("lit_respawn_X0_range", int'(px[0] >= 32 && px[0] <= 479), 1);
    check("lit_Y1_452", int'(py[1]), 452);
    check("lit_score11", int'(score), 11);
    doFrame(10'd100, 10'h3EC);
    @(negedge Clk);
    check("lit_sat_scroll", int'(scroll_amt), 15);
    check("lit_sat_score", int'(score), 26);
    for (int k = 0; k < 30; k++)
      doFrame(10'($urandom_range(0, 399)),
              $urandom_range(0, 1) == 1 ? 10'(10'h3F0 + $urandom_range(0, 15)) : 10'($urandom_range(0, 1023)));
    doLoad(cyc);
    chk = 0;
    @(negedge Clk);
    DoodleY = 150;
    Doodle_Y_Motion = 10'h3FD;
    frame_clk = 1;
    waitBusy(1, 20, ok, n);
    check("abort_busy_rise", ok, 1);
    repeat (6) @(negedge Clk);
    loadplat = 1;
    mScore = 0;
    modelLoad();
    waitBusy(0, 60, ok, n);
    check("abort_busy_fall", ok, 1);
    loadplat = 0;
    frame_clk = 0;
    repeat (4) @(negedge Clk);
    chk = 1;
    @(negedge Clk);
    check("lit_abort_score", int'(score), 0);
    check("lit_abort_Y0", int'(py[0]), 471);
    check("lit_abort_Y15", int'(py[15]), 21);
    check("lit_abort_X0", int'(px[0]), 320);
    chk = 0;
    @(negedge Clk);
    loadplat = 1;
    waitBusy(1, 20, ok, n);
    check("rst_busy_rise", ok, 1);
    repeat (5) @(negedge Clk);
    Reset = 0;
    loadplat = 0;
    #1;
    check("lit_rst_busy", int'(busy), 0);
    check("lit_rst_Y0", int'(py[0]), 0);
    check("lit_rst_score", int'(score), 0);
    modelReset();
    chk = 1;
    repeat (5) @(negedge Clk);
    Reset = 1;
    repeat (5) @(negedge Clk);
    doLoad(cyc);
    check("reload_busy_cycles", cyc, 17);
    doFrame(10'd20, 10'h3F8);
    repeat (20) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
